// File: rtl/sram_pkg.sv
// Shared definitions for the two-port scratch SRAM with clear engine.
//   state_t  : clear-engine FSM states
//   RDW_OLD / RDW_NEW : same-address read-during-write behaviour selectors
//   calc_nb  : number of byte-enable lanes for a given word/lane width
package sram_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int calc_nb(input int data_width, input int byte_w);
    return data_width / byte_w;
  endfunction

endpackage : sram_pkg

// File: rtl/sram_clr_ctrl.sv
// Clear engine for sram_2p_clr. Sweeps every address writing zero, once after
// reset and again whenever clr_req is seen while idle.
//   clk, rst_n : clock / asynchronous active-low reset
//   clr_req    : request a full-array clear (honoured only in S_READY)
//   busy       : high for the whole sweep
//   clr_we     : clear write strobe for the array
//   clr_addr   : address being cleared this cycle
module sram_clr_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr_reg, clr_ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    busy         = 1'b0;
    clr_we       = 1'b0;
    clr_addr     = clr_ptr_reg;
    case (state_reg)
      S_CLEAR: begin
        busy         = 1'b1;
        clr_we       = 1'b1;
        // The pointer wraps back to zero on the final address, so it is
        // already parked at 0 for the next sweep.
        clr_ptr_next = clr_ptr_reg + 1'b1;
        if (&clr_ptr_reg) begin
          state_next = S_READY;
        end
      end
      S_READY: begin
        if (clr_req) begin
          state_next   = S_CLEAR;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = S_CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

endmodule : sram_clr_ctrl

// File: rtl/sram_2p_clr.sv
// Simple dual-port SRAM (one write, one read per cycle) with byte-lane write
// enables, registered read with valid strobe, and a built-in zeroing engine.
//   clk, rst_n          : clock / asynchronous active-low reset
//   clr_req, busy       : start a clear / clear in progress (ports ignored)
//   wr_en, wr_addr,
//   wr_be, wr_data      : write port, wr_be[i] covers data[i*BYTE_W +: BYTE_W]
//   rd_en, rd_addr      : read request
//   rd_data, rd_valid   : read result one cycle after the request
module sram_2p_clr
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_W     = 8,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    clr_req,
  output logic                                    busy,
  input  logic                                    wr_en,
  input  logic [ADDR_WIDTH-1:0]                   wr_addr,
  input  logic [calc_nb(DATA_WIDTH, BYTE_W)-1:0]  wr_be,
  input  logic [DATA_WIDTH-1:0]                   wr_data,
  input  logic                                    rd_en,
  input  logic [ADDR_WIDTH-1:0]                   rd_addr,
  output logic [DATA_WIDTH-1:0]                   rd_data,
  output logic                                    rd_valid
);

  localparam int NB    = calc_nb(DATA_WIDTH, BYTE_W);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("sram_2p_clr: DATA_WIDTH must be a multiple of BYTE_W");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  rd_valid_reg;

  sram_clr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User ports are locked out for the whole sweep; the clear owns the write
  // port while busy.
  assign wr_fire  = wr_en & ~busy;
  assign rd_fire  = rd_en & ~busy;
  assign mem_addr = clr_we ? clr_addr : wr_addr;

  // Each byte lane is its own memory so every lane has a single writer and
  // maps onto a plain write-enable RAM.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [BYTE_W-1:0] mem_lane [DEPTH];
    logic [BYTE_W-1:0] rd_lane_reg;
    logic              lane_we;
    logic [BYTE_W-1:0] lane_wdata;
    logic              rd_bypass;

    assign lane_we    = clr_we | (wr_fire & wr_be[gi]);
    assign lane_wdata = clr_we ? '0 : wr_data[gi*BYTE_W +: BYTE_W];
    // In new-data mode an enabled lane written to the address being read
    // forwards straight from wr_data; disabled lanes still read the array.
    assign rd_bypass  = (RDW_MODE == RDW_NEW) && wr_fire && wr_be[gi] &&
                        (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
      if (lane_we) begin
        mem_lane[mem_addr] <= lane_wdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_lane_reg <= '0;
      end else if (rd_fire) begin
        rd_lane_reg <= rd_bypass ? wr_data[gi*BYTE_W +: BYTE_W]
                                 : mem_lane[rd_addr];
      end
    end

    assign rd_data[gi*BYTE_W +: BYTE_W] = rd_lane_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
    end
  end

  assign rd_valid = rd_valid_reg;

endmodule : sram_2p_clr

// File: tb/tb_sram_2p_clr.sv
module tb_sram_2p_clr;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic          busy_o, busy_n;
  logic [DW-1:0] rd_data_o, rd_data_n;
  logic          rd_valid_o, rd_valid_n;

  always #5 clk = ~clk;

  sram_2p_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_W(8), .RDW_MODE(0)) u_old (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_o),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o), .rd_valid(rd_valid_o)
  );

  sram_2p_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_W(8), .RDW_MODE(1)) u_new (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_valid(rd_valid_n)
  );

  // Reference model: word array plus "cycles of clearing left".
  logic [DW-1:0] ref_mem [DEPTH];
  int            busy_left;
  logic [DW-1:0] exp_rd_old, exp_rd_new;
  logic          exp_valid;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_left  = DEPTH;
    exp_rd_old = '0;
    exp_rd_new = '0;
    exp_valid  = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".busy_old"},  {15'd0, busy_o},     {15'd0, busy_left > 0});
    check({tag, ".busy_new"},  {15'd0, busy_n},     {15'd0, busy_left > 0});
    check({tag, ".valid_old"}, {15'd0, rd_valid_o}, {15'd0, exp_valid});
    check({tag, ".valid_new"}, {15'd0, rd_valid_n}, {15'd0, exp_valid});
    check({tag, ".data_old"},  rd_data_o, exp_rd_old);
    check({tag, ".data_new"},  rd_data_n, exp_rd_new);
  endtask

  // One clock cycle: drive, update the model from pre-edge state, check after edge.
  task automatic step(input string tag, input logic we, input logic [AW-1:0] wa,
                      input logic [1:0] be, input logic [DW-1:0] wd,
                      input logic re, input logic [AW-1:0] ra, input logic clr);
    logic [DW-1:0] old_word, merged;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra; clr_req = clr;
    if (busy_left > 0) begin
      busy_left--;
      exp_valid = 1'b0;
    end else begin
      old_word = ref_mem[ra];
      merged   = ref_mem[wa];
      for (int b = 0; b < 2; b++) if (be[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
      exp_valid = re;
      if (re) begin
        exp_rd_old = old_word;
        exp_rd_new = (we && wa == ra) ? merged : old_word;
      end
      if (we) ref_mem[wa] = merged;
      if (clr) begin
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    $display("[%0t] %s we=%0b wa=%0d be=%b wd=%h re=%0b ra=%0d clr=%0b -> busy=%0b valid=%0b old=%h new=%h",
             $time, tag, we, wa, be, wd, re, ra, clr, busy_o, rd_valid_o, rd_data_o, rd_data_n);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 2'b00, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input string tag, input logic [AW-1:0] a, input logic [1:0] be, input logic [DW-1:0] d);
    step(tag, 1'b1, a, be, d, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a);
    step(tag, 1'b0, '0, 2'b00, '0, 1'b1, a, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0;
    wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    model_reset();
    #2;
    check_outputs("reset");
    #1 rst_n = 1'b1;

    // Power-up clear: busy for exactly DEPTH edges.
    for (int i = 0; i < DEPTH; i++) idle("init_clear");
    check("init_busy_done", {15'd0, busy_o}, 16'd0);

    // Whole array reads back zero.
    for (int a = 0; a < DEPTH; a++) rd("read_zero", a[AW-1:0]);
    check("zero_last", rd_data_o, 16'h0000);
    idle("idle");

    // Byte-lane merge.
    wr("wr_full", 4'd3, 2'b11, 16'hBEEF);
    wr("wr_lane0", 4'd3, 2'b01, 16'h1234);
    rd("rd_merge", 4'd3);
    check("merge_const", rd_data_o, 16'hBE34);

    // Read-during-write on the same address.
    wr("wr_5555", 4'd5, 2'b11, 16'h5555);
    step("rdw", 1'b1, 4'd5, 2'b11, 16'hAAAA, 1'b1, 4'd5, 1'b0);
    check("rdw_old_const", rd_data_o, 16'h5555);
    check("rdw_new_const", rd_data_n, 16'hAAAA);
    rd("rdw_after", 4'd5);
    check("rdw_after_const", rd_data_o, 16'hAAAA);

    // Fill, clear with a concurrent read, dropped write during busy.
    for (int a = 0; a < DEPTH; a++) wr("fill", a[AW-1:0], 2'b11, 16'(a * 16'h0101));
    step("clr_rd", 1'b0, '0, 2'b00, '0, 1'b1, 4'd2, 1'b1);
    check("clr_rd_const", rd_data_o, 16'h0202);
    check("clr_busy_const", {15'd0, busy_o}, 16'd1);
    step("busy_wr", 1'b1, 4'd7, 2'b11, 16'hFFFF, 1'b1, 4'd7, 1'b0);
    while (busy_left > 0) idle("clearing");
    rd("rd7_after_clr", 4'd7);
    check("rd7_const", rd_data_o, 16'h0000);

    // Streaming reads then hold.
    for (int a = 0; a < 4; a++) wr("fill4", a[AW-1:0], 2'b11, 16'hC0DE + 16'(a));
    for (int a = 0; a < 4; a++) rd("stream", a[AW-1:0]);
    idle("hold1");
    idle("hold2");
    check("hold_const", rd_data_o, 16'hC0E1);

    // Reset in the middle of a clear (clr_ptr = 9).
    step("clr2", 1'b0, '0, 2'b00, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) idle("mid_clear");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("async_reset");
    #2 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) idle("post_reset_clear");
    check("post_reset_busy", {15'd0, busy_o}, 16'd0);

    // Random traffic; small address window raises same-address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, ra;
      wa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      step("rand", 1'($urandom), wa, 2'($urandom), 16'($urandom), 1'($urandom), ra,
           $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sram_2p_clr

// File: doc/sram_2p_clr.md
Name: sram_2p_clr

Overview:
Parametrised simple-dual-port SRAM: one write port and one read port per cycle, with byte-lane write enables and a registered read that carries a valid strobe. A built-in clear engine zeroes the whole array after reset and on request, and reports busy while it runs. It is the next-generation scratch memory for sequence and datapath blocks, replacing the single-port 16x8 store.

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 16, word width in bits
BYTE_W, 8, bits per write-enable lane; DATA_WIDTH must be a multiple of BYTE_W; NB = DATA_WIDTH/BYTE_W
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (bypass)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
clr_req  in  1  start a full-array clear (pulse)
busy  out  1  clear in progress; ports not accepting
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_be  in  NB  per-lane write enable; bit i covers data[i*BYTE_W +: BYTE_W]
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  rd_data updated this cycle

Behaviour:
- Reset (async assert, sync release): rd_data=0, rd_valid=0, busy=1, state=CLEAR, clr_ptr=0. The array itself has no reset; it is zeroed only by the clear engine.
- States:
  - CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr. At clr_ptr==DEPTH-1, after that write, go to READY.
  - READY: normal operation. If clr_req=1, go to CLEAR with clr_ptr=0.
- busy=1 exactly while in CLEAR. A clear takes DEPTH cycles; after rst_n deasserts, busy falls after DEPTH rising edges.
- While busy=1: wr_en, rd_en and clr_req are ignored. No write occurs, rd_valid stays 0 and rd_data holds.
- Write (READY, wr_en=1): at the edge, for each i with wr_be[i]=1, the lane of mem[wr_addr] takes the wr_data lane. Lanes with wr_be[i]=0 are unchanged. wr_be=0 is a no-op.
- Read (READY, rd_en=1), latency 1:
  - The edge after request N sets rd_data = mem[rd_addr] and rd_valid=1 for one cycle.
  - Back-to-back reads give one result per cycle.
  - With rd_en=0, rd_valid=0 and rd_data holds its last value (it is not cleared).
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: rd_data returns the pre-write word.
  - RDW_MODE=1: rd_data returns the merged word, i.e. enabled lanes from wr_data and the other lanes from the old word.
  - Different addresses never interact.
- clr_req in the same READY cycle as wr_en/rd_en: the write and read are still performed, and the read returns pre-clear data next cycle. CLEAR starts on the following cycle and overwrites everything.
- rst_n asserted mid-clear or mid-read: outputs return to reset values immediately, and the clear restarts from address 0 after release.
- Address width is exact: no out-of-range addresses exist and no wrap logic is needed. clr_ptr is ADDR_WIDTH bits wide, and the terminal compare is against all-ones.

Decomposition:
- Package sram_pkg holds:
  - state typedef {S_CLEAR, S_READY}
  - RDW_OLD=0 and RDW_NEW=1 constants
  - a function computing NB
- One natural sub-module: sram_clr_ctrl, containing the FSM, clr_ptr and busy, with outputs clr_we and clr_addr. The top level muxes the clear write over the user write port.
- Parameter legality (DATA_WIDTH % BYTE_W == 0) is checked with an elaboration-time assertion.

Test Plan:
- Reset release, then poll busy -> busy=1 for exactly 16 cycles, then 0. Reading addresses 0..15 returns 0x0000 each, with rd_valid=1 one cycle after each rd_en.
- Write 0xBEEF to address 3 with wr_be=2'b11, then write 0x1234 to address 3 with wr_be=2'b01, then read address 3 -> 0xBE34.
- Same-cycle write of 0xAAAA and read of address 5, where mem[5]=0x5555 -> RDW_MODE=0 returns 0x5555; RDW_MODE=1 returns 0xAAAA. A following read returns 0xAAAA in both modes.
- Fill all addresses with value = addr*0x0101, pulse clr_req with rd_en on address 2 -> next cycle rd_data=0x0202 and busy=1. During busy, wr_en to address 7 is dropped. After 16 cycles, read address 7 -> 0x0000.
- Stream reads of addresses 0,1,2,3 on consecutive cycles -> rd_valid held high for 4 cycles with data in order. rd_en low afterwards -> rd_valid=0 and rd_data holds the last word.
- Assert rst_n mid-clear at clr_ptr=9 -> rd_data=0, rd_valid=0, busy=1 immediately. After release, busy lasts a full 16 cycles.
